mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the core's single-word request/response bus, the bus that fetch and the memory stage drive as initiators.
- Accepts one-cycle request pulses (read or write, with byte strobes) and services them from an internal word-addressed memory array.
- Returns a one-cycle response pulse a fixed number of cycles later.
- Buffers one request that arrives while the block is busy, so initiators that pulse back-to-back are not lost.

Parameters:
- ADDR_WIDTH, 12: word-address bits; the array holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2: cycles from the cycle a request is accepted to its response_enable pulse; legal range 1 to 15.
- BASE, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rstn, input, 1: reset, asynchronous, active-low.
- request_enable, input, 1: one-cycle request strobe from the initiator.
- mode, input, 1: MEMREQ_READ = 0, MEMREQ_WRITE = 1.
- addr, input, 32: byte address; addr[1:0] is ignored.
- wdata, input, 32: write data.
- wstrb, input, 4: byte enables for writes; bit i enables wdata[8i+7:8i].
- response_enable, output, 1: one-cycle pulse marking completion of the request at the head.
- data, output, 32: read data; valid while response_enable = 1.
- error, output, 1: one-cycle pulse, coincident with response_enable, when the address was out of range.
- busy, output, 1: high while a request is in flight.
- overrun, output, 1: sticky; set when a request is dropped.

Behaviour:
- Reset: clk and rstn are the only clock and reset. rstn low asynchronously forces:
  - state IDLE
  - response_enable = 0, data = 0, error = 0, busy = 0, overrun = 0
  - latency counter cleared, pending slot emptied
  - An in-flight request is discarded and never gets a response.
  - Array contents are not touched by reset; at simulation time zero they are zero.
- In range means BASE <= addr < BASE + 4*2^ADDR_WIDTH. Word index = (addr - BASE) >> 2.
- States:
  - IDLE:
    - request_enable = 1 latches mode, addr, wdata and wstrb into the active slot.
    - Loads counter = LATENCY-1 and sets busy = 1 on the next edge.
    - If LATENCY = 1, goes to RESPOND; otherwise goes to WAIT.
  - WAIT: the counter decrements each cycle; when it reaches 1 the next state is RESPOND.
  - RESPOND (exactly one cycle, driven from registered outputs):
    - response_enable = 1.
    - Read, in range: data = array[index], the value before any write in this same cycle.
    - Write, in range: bytes selected by wstrb are written at this edge; data = 0.
    - Out of range: data = 0, error = 1, no write.
    - Next state: if the pending slot is full, promote it to active, reload the counter and keep busy = 1 (WAIT, or RESPOND if LATENCY = 1). Otherwise go to IDLE with busy = 0.
- Timing: response_enable rises exactly LATENCY cycles after the edge that sampled request_enable = 1.
- Pending slot (one deep):
  - request_enable = 1 while in WAIT or RESPOND, with the slot empty, captures the request into the slot.
  - A pending request's latency starts at promotion, so its response comes LATENCY cycles after the previous response.
  - request_enable = 1 while busy with the slot full drops the request and sets overrun = 1. overrun is cleared only by reset.
- Ordering: responses come back in acceptance order. A pending read that follows a write to the same word returns the written data.
- response_enable, error and data never assert outside RESPOND. data returns to 0 the cycle after RESPOND.
- wstrb = 0 on a write: no bytes change, but the response is still produced.
- mode, addr, wdata and wstrb are sampled only in cycles where request_enable = 1.

Test Plan:
- Reset, write addr 0x10 wdata 0xDEADBEEF wstrb 4'hF, then read 0x10 -> each response_enable pulse arrives 2 cycles after its request; the read data = 0xDEADBEEF.
- Write 0x20 = 0x11223344, then write 0x20 wdata 0xAABBCCDD wstrb 4'b0101, then read 0x20 -> data = 0x11BB33DD.
- Read 0x4000 with ADDR_WIDTH = 12 (out of range) -> response_enable and error both pulse at latency 2, data = 0; a following read of 0x0 shows memory unchanged.
- Three requests on consecutive cycles: write 0x8 = 5, read 0x8, read 0xC:
  - Write accepted, read 0x8 pending, read 0xC dropped with overrun = 1.
  - Responses at +2 and +4 cycles; the second returns 5.
- Read issued, then rstn pulsed low for 1 cycle mid-WAIT -> no response_enable ever appears for that read; busy = 0 and overrun = 0 after reset. A new read after reset returns at latency 2.
- With LATENCY = 1, back-to-back read pulses spaced 2 cycles apart -> each response exactly 1 cycle after its request, busy drops between them, overrun stays 0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the core's single-word
// request/response bus. Requests are serviced from an internal word array
// and answered with a one-cycle response pulse a fixed LATENCY after they
// are accepted. One extra request may wait in a pending slot while busy.
//
// Handshake: there is no ready. A request is a one-cycle request_enable
// pulse with mode/addr/wdata/wstrb valid in that cycle. It is accepted when
// the block is idle, when the pending slot is empty, or during the response
// cycle if the pending slot is empty. Otherwise it is dropped and overrun is
// set. Every accepted request produces exactly one response_enable pulse,
// with data/error valid only in that pulse, in acceptance order.
//
// Timing: the RESPOND state is the cycle in which the response is formed.
// The response registers load on the edge that leaves RESPOND, so the pulse
// is visible LATENCY cycles after the accepting edge. Writes commit on that
// same edge, and read data is taken from the array before that write.
module mem_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        request_enable,
    input  logic        mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        response_enable,
    output logic [31:0] data,
    output logic        error,
    output logic        busy,
    output logic        overrun
);

    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
    localparam logic       MEMREQ_WRITE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    // With a one-cycle latency there is no WAIT cycle at all.
    localparam state_t S_START = (LATENCY == 1) ? S_RESPOND : S_WAIT;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;

    // Active slot: the request currently being timed / answered.
    logic        act_mode;
    logic [29:0] act_word;
    logic [31:0] act_wdata;
    logic [3:0]  act_wstrb;

    // Pending slot: one request that arrived while busy.
    logic        pend_valid;
    logic        pend_mode;
    logic [29:0] pend_word;
    logic [31:0] pend_wdata;
    logic [3:0]  pend_wstrb;

    // Memory array; not reset, so contents survive rstn.
    logic [31:0] mem [DEPTH];

    // Decode of the active request.
    logic [29:0]           off_word;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           rd_word;

    // Slot control.
    logic take_input;
    logic promote;
    logic capture_pend;
    logic drop;
    logic is_respond;

    // The byte offset bits of addr never matter: accesses are whole words.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr[1:0]};

    // Word-granular address decode; BASE is word aligned.
    always_comb begin
        off_word = act_word - BASE[31:2];
        in_range = (act_word >= BASE[31:2]) && ((off_word >> ADDR_WIDTH) == 30'd0);
        idx      = off_word[ADDR_WIDTH-1:0];
        rd_word  = mem[idx];
    end

    // Decide where an incoming request goes this cycle.
    always_comb begin
        is_respond   = (state == S_RESPOND);
        // Straight into the active slot: idle, or the response cycle with
        // nothing waiting behind it.
        take_input   = request_enable &&
                       ((state == S_IDLE) || (is_respond && !pend_valid));
        promote      = is_respond && pend_valid;
        capture_pend = request_enable && (state == S_WAIT) && !pend_valid;
        drop         = request_enable && (state != S_IDLE) && pend_valid;
    end

    // Next-state logic and latency counter.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (request_enable) begin
                    state_nx = S_START;
                    cnt_nx   = LAT_M1;
                end
            end
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nx = S_RESPOND;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_RESPOND: begin
                if (pend_valid || request_enable) begin
                    state_nx = S_START;
                    cnt_nx   = LAT_M1;
                end else begin
                    state_nx = S_IDLE;
                    cnt_nx   = 4'd0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // State register, counter and busy flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            busy  <= (state_nx != S_IDLE);
        end
    end

    // Active slot: loaded from the bus or promoted from the pending slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_mode  <= 1'b0;
            act_word  <= 30'd0;
            act_wdata <= 32'd0;
            act_wstrb <= 4'd0;
        end else if (take_input) begin
            act_mode  <= mode;
            act_word  <= addr[31:2];
            act_wdata <= wdata;
            act_wstrb <= wstrb;
        end else if (promote) begin
            act_mode  <= pend_mode;
            act_word  <= pend_word;
            act_wdata <= pend_wdata;
            act_wstrb <= pend_wstrb;
        end
    end

    // Pending slot: filled during WAIT, emptied on promotion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_valid <= 1'b0;
            pend_mode  <= 1'b0;
            pend_word  <= 30'd0;
            pend_wdata <= 32'd0;
            pend_wstrb <= 4'd0;
        end else if (promote) begin
            pend_valid <= 1'b0;
        end else if (capture_pend) begin
            pend_valid <= 1'b1;
            pend_mode  <= mode;
            pend_word  <= addr[31:2];
            pend_wdata <= wdata;
            pend_wstrb <= wstrb;
        end
    end

    // Sticky overrun: a request arrived with both slots occupied.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end
    end

    // Response registers: loaded only on the edge leaving RESPOND.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            response_enable <= 1'b0;
            error           <= 1'b0;
            data            <= 32'd0;
        end else begin
            response_enable <= is_respond;
            error           <= is_respond && !in_range;
            if (is_respond && in_range && (act_mode != MEMREQ_WRITE)) begin
                data <= rd_word;
            end else begin
                data <= 32'd0;
            end
        end
    end

    // Byte-masked write, committed on the edge leaving RESPOND.
    always_ff @(posedge clk) begin
        if (is_respond && in_range && (act_mode == MEMREQ_WRITE)) begin
            for (int b = 0; b < 4; b++) begin
                if (act_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= act_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=2 instance (dut0) and a LATENCY=1
// instance (dut1) share the request fields but have separate strobes.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        req0, rsp0, err0, busy0, ovr0;
    logic [31:0] data0;
    logic        req1, rsp1, err1, busy1, ovr1;
    logic [31:0] data1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Scoreboard: expected {error, data} and expected edge index of each pulse.
    logic [32:0] exp_q0[$];
    int          exp_t0[$];
    logic [32:0] exp_q1[$];
    int          exp_t1[$];
    // Edges at which currently scheduled responses will appear.
    int          sched0[$];
    int          sched1[$];
    // Memory models and overrun models.
    logic [31:0] mdl0 [4096];
    logic [31:0] mdl1 [4096];
    logic        ovr_m0 = 1'b0;
    logic        ovr_m1 = 1'b0;

    logic [32:0] mev0, mev1;
    int          met0, met1;

    mem_responder #(.ADDR_WIDTH(12), .LATENCY(2), .BASE(32'h0)) dut0 (
        .clk(clk), .rstn(rstn), .request_enable(req0), .mode(mode), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .response_enable(rsp0), .data(data0),
        .error(err0), .busy(busy0), .overrun(ovr0)
    );

    mem_responder #(.ADDR_WIDTH(12), .LATENCY(1), .BASE(32'h0)) dut1 (
        .clk(clk), .rstn(rstn), .request_enable(req1), .mode(mode), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .response_enable(rsp1), .data(data1),
        .error(err1), .busy(busy1), .overrun(ovr1)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, observed cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard compare on the falling edge.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (rsp0) begin
                if (exp_q0.size() == 0) begin
                    chk("rsp0_unexpected", 33'(rsp0), 33'h0);
                end else begin
                    mev0 = exp_q0.pop_front();
                    met0 = exp_t0.pop_front();
                    chk("rsp0_data", {err0, data0}, mev0);
                    chk("rsp0_time", 33'(cyc), 33'(met0));
                end
            end else begin
                chk("idle0_out", {err0, data0}, 33'h0);
            end
            if (rsp1) begin
                if (exp_q1.size() == 0) begin
                    chk("rsp1_unexpected", 33'(rsp1), 33'h0);
                end else begin
                    mev1 = exp_q1.pop_front();
                    met1 = exp_t1.pop_front();
                    chk("rsp1_data", {err1, data1}, mev1);
                    chk("rsp1_time", 33'(cyc), 33'(met1));
                end
            end else begin
                chk("idle1_out", {err1, data1}, 33'h0);
            end
        end
    end

    // Drive one request pulse to instance inst and predict its outcome.
    task automatic send(input bit inst, input logic m, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws);
        int          e, lat, last, resp, idx;
        bit          drop;
        logic [31:0] w;
        logic [32:0] ev;
        @(negedge clk);
        e    = cyc + 1;
        lat  = inst ? 1 : 2;
        last = 0;
        if (!inst) begin
            while (sched0.size() > 0 && sched0[0] < e) void'(sched0.pop_front());
            drop = (sched0.size() >= 2);
            if (sched0.size() > 0) last = sched0[$];
        end else begin
            while (sched1.size() > 0 && sched1[0] < e) void'(sched1.pop_front());
            drop = (sched1.size() >= 2);
            if (sched1.size() > 0) last = sched1[$];
        end
        if (drop) begin
            if (!inst) ovr_m0 = 1'b1; else ovr_m1 = 1'b1;
        end else begin
            resp = ((last > e) ? last : e) + lat;
            if (a < 32'h4000) begin
                idx = int'(a[13:2]);
                w   = inst ? mdl1[idx] : mdl0[idx];
                if (m) begin
                    for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
                    if (inst) mdl1[idx] = w; else mdl0[idx] = w;
                    ev = 33'h0;
                end else begin
                    ev = {1'b0, w};
                end
            end else begin
                ev = {1'b1, 32'h0};
            end
            if (!inst) begin
                exp_q0.push_back(ev); exp_t0.push_back(resp); sched0.push_back(resp);
            end else begin
                exp_q1.push_back(ev); exp_t1.push_back(resp); sched1.push_back(resp);
            end
        end
        mode  = m;
        addr  = a;
        wdata = wd;
        wstrb = ws;
        if (inst) req1 = 1'b1; else req0 = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // Wait, bounded, for every expected response to arrive.
    task automatic drain();
        for (int i = 0; i < 20 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) @(negedge clk);
        chk("drain0", 33'(exp_q0.size()), 33'h0);
        chk("drain1", 33'(exp_q1.size()), 33'h0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mdl0[i] = 32'h0;
            mdl1[i] = 32'h0;
        end
        rstn = 1'b0; req0 = 1'b0; req1 = 1'b0;
        mode = 1'b0; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy0", 33'(busy0), 33'h0);
        chk("rst_rsp0", 33'(rsp0), 33'h0);
        chk("rst_out0", {err0, data0}, 33'h0);
        chk("rst_ovr0", 33'(ovr0), 33'h0);
        chk("rst_busy1", 33'(busy1), 33'h0);
        rstn = 1'b1;
        @(negedge clk);

        // Full-word write then read back.
        send(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("busy0_accept", 33'(busy0), 33'h1);
        drain();
        send(0, 1'b0, 32'h10, 32'h0, 4'h0);
        drain();

        // Partial byte strobes.
        send(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
        drain();
        send(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        drain();
        send(0, 1'b0, 32'h20, 32'h0, 4'h0);
        drain();

        // Out of range, then memory unchanged; top in-range word.
        send(0, 1'b0, 32'h4000, 32'h0, 4'h0);
        drain();
        send(0, 1'b1, 32'h4000, 32'hFFFFFFFF, 4'hF);
        drain();
        send(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drain();
        send(0, 1'b1, 32'h3FFE, 32'h12345678, 4'hF);
        drain();
        send(0, 1'b0, 32'h3FFC, 32'h0, 4'h0);
        drain();

        // wstrb = 0 write leaves the word intact but still responds.
        send(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
        drain();
        send(0, 1'b0, 32'h10, 32'h0, 4'h0);
        drain();

        // Back-to-back: accept, pend, drop.
        send(0, 1'b1, 32'h8, 32'h5, 4'hF);
        send(0, 1'b0, 32'h8, 32'h0, 4'h0);
        send(0, 1'b0, 32'hC, 32'h0, 4'h0);
        drain();
        chk("ovr0_drop", 33'(ovr0), 33'(ovr_m0));

        // Request landing in the response cycle with an empty slot.
        send(0, 1'b1, 32'h30, 32'h00000077, 4'hF);
        @(posedge clk);
        send(0, 1'b0, 32'h30, 32'h0, 4'h0);
        drain();
        chk("ovr0_sticky", 33'(ovr0), 33'(ovr_m0));

        // Reset mid-WAIT discards the in-flight read.
        send(0, 1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        rstn = 1'b0;
        exp_q0.delete(); exp_t0.delete(); sched0.delete();
        exp_q1.delete(); exp_t1.delete(); sched1.delete();
        ovr_m0 = 1'b0; ovr_m1 = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("rst2_busy0", 33'(busy0), 33'h0);
        chk("rst2_ovr0", 33'(ovr0), 33'(ovr_m0));
        repeat (6) @(negedge clk);
        send(0, 1'b0, 32'h10, 32'h0, 4'h0);
        drain();

        // LATENCY = 1 instance, requests two cycles apart.
        send(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
        chk("busy1_a", 33'(busy1), 33'h1);
        @(posedge clk); #1;
        chk("busy1_gap_a", 33'(busy1), 33'h0);
        send(1, 1'b0, 32'h40, 32'h0, 4'h0);
        chk("busy1_b", 33'(busy1), 33'h1);
        @(posedge clk); #1;
        chk("busy1_gap_b", 33'(busy1), 33'h0);
        send(1, 1'b0, 32'h44, 32'h0, 4'h0);
        drain();
        chk("ovr1", 33'(ovr1), 33'(ovr_m1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
